countdown_timer_with_enable: RTL and testbench

Loadable down-counting timer: the decrementing counterpart of the up-counter with enable. Software or a controlling FSM loads a start value and starts the timer. The timer then decrements once per clock while `enable` is high. It signals expiry with a one-cycle `done` pulse and can optionally reload itself for periodic ticks. It sits beside the up-counter in timing/sequencing logic, for example as a timeout or tick generator.

---
 rtl/countdown_timer_with_enable_pkg.sv | 13 +
 rtl/countdown_timer_with_enable_if.sv | 17 +
 rtl/countdown_timer_with_enable_down_counter_core.sv | 26 ++
 rtl/countdown_timer_with_enable.sv | 96 +++++++++
 tb/tb_countdown_timer_with_enable.sv | 156 +++++++++++++++
 5 files changed

// File: rtl/countdown_timer_with_enable_pkg.sv
// Shared definitions for the countdown timer and its sibling counters:
// state encodings and state width.
package countdown_timer_with_enable_pkg;

  localparam int STATE_W = 2;

  typedef enum logic [STATE_W-1:0] {
    ST_IDLE    = 2'd0,
    ST_RUN     = 2'd1,
    ST_EXPIRED = 2'd2
  } state_e;

endpackage

// File: rtl/countdown_timer_with_enable_if.sv
// Control/status bundle of the countdown timer; master drives commands,
// slave (the timer) returns count, busy and done.
interface countdown_timer_with_enable_if #(parameter int WIDTH = 8);
  logic             enable;
  logic             load;
  logic [WIDTH-1:0] load_value;
  logic             start;
  logic             stop;
  logic [WIDTH-1:0] count;
  logic             busy;
  logic             done;

  modport master (output enable, load, load_value, start, stop,
                  input  count, busy, done);
  modport slave  (input  enable, load, load_value, start, stop,
                  output count, busy, done);
endinterface

// File: rtl/countdown_timer_with_enable_down_counter_core.sv
// Loadable saturating down counter with reload path and terminal (==1) flag.
module down_counter_core #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load,
  input  logic [WIDTH-1:0] load_value,
  input  logic             dec,
  input  logic             reload,
  input  logic [WIDTH-1:0] reload_value,
  output logic [WIDTH-1:0] count,
  output logic             term
);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset)                   count <= '0;
    else if (load)                count <= load_value;
    else if (reload)              count <= reload_value;
    // Saturate at zero so the counter can never wrap to all-ones.
    else if (dec && count != '0)  count <= count - 1'b1;
  end

  assign term = (count == WIDTH'(1));

endmodule

// File: rtl/countdown_timer_with_enable.sv
// Countdown timer: FSM, reload register and registered busy/done around
// a down_counter_core. Optional auto-reload for periodic ticks.
module countdown_timer_with_enable
  import countdown_timer_with_enable_pkg::*;
#(
  parameter int WIDTH       = 8,
  parameter bit AUTO_RELOAD = 1'b0
) (
  input  logic                                 clk,
  input  logic                                 reset,
  countdown_timer_with_enable_if.slave         tif
);

  state_e           state_q, state_d;
  logic [WIDTH-1:0] reload_q;
  logic [WIDTH-1:0] cnt;
  logic             term;
  logic             cnt_load, cnt_dec, cnt_reload, done_d;
  logic             busy_q, done_q;
  logic             do_reload;

  // Reload only makes sense with a non-zero period.
  assign do_reload = AUTO_RELOAD && (reload_q != '0);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state_q <= ST_IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    if (tif.load) begin
      state_d = ST_IDLE;
    end else begin
      case (state_q)
        ST_RUN: begin
          if (tif.stop)                        state_d = ST_IDLE;
          else if (tif.enable && term && !do_reload) state_d = ST_EXPIRED;
        end
        ST_IDLE, ST_EXPIRED: begin
          if (tif.start) state_d = (cnt != '0) ? ST_RUN : ST_EXPIRED;
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  always_comb begin
    cnt_load   = tif.load;
    cnt_dec    = 1'b0;
    cnt_reload = 1'b0;
    done_d     = 1'b0;
    if (!tif.load) begin
      case (state_q)
        ST_RUN: begin
          if (!tif.stop && tif.enable) begin
            done_d     = term;
            cnt_reload = term && do_reload;
            cnt_dec    = !(term && do_reload);
          end
        end
        ST_IDLE, ST_EXPIRED: done_d = tif.start && (cnt == '0);
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      reload_q <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      if (tif.load) reload_q <= tif.load_value;
      busy_q <= (state_d == ST_RUN);
      done_q <= done_d;
    end
  end

  down_counter_core #(.WIDTH(WIDTH)) u_core (
    .clk          (clk),
    .reset        (reset),
    .load         (cnt_load),
    .load_value   (tif.load_value),
    .dec          (cnt_dec),
    .reload       (cnt_reload),
    .reload_value (reload_q),
    .count        (cnt),
    .term         (term)
  );

  assign tif.count = cnt;
  assign tif.busy  = busy_q;
  assign tif.done  = done_q;

endmodule

// File: tb/tb_countdown_timer_with_enable.sv
// Bench for countdown_timer_with_enable: one stop-at-zero and one
// auto-reload instance, expected values queued at drive time, popped after the edge.
module tb_countdown_timer_with_enable;

  logic clk = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;

  countdown_timer_with_enable_if #(.WIDTH(8)) if0 ();
  countdown_timer_with_enable_if #(.WIDTH(8)) if1 ();

  countdown_timer_with_enable #(.WIDTH(8), .AUTO_RELOAD(1'b0)) u0 (
    .clk(clk), .reset(reset), .tif(if0.slave));
  countdown_timer_with_enable #(.WIDTH(8), .AUTO_RELOAD(1'b1)) u1 (
    .clk(clk), .reset(reset), .tif(if1.slave));

  typedef struct {
    string      tag;
    int         sel;
    logic [7:0] cnt;
    logic       busy;
    logic       done;
  } exp_t;

  exp_t exp_q[$];
  int   n_chk = 0;
  int   n_err = 0;
  int   n_done1 = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic drive(input int sel, input bit en, input bit ld, input logic [7:0] lv,
                       input bit st, input bit sp);
    if0.enable = (sel == 0) ? en : 1'b0;  if1.enable = (sel == 1) ? en : 1'b0;
    if0.load   = (sel == 0) ? ld : 1'b0;  if1.load   = (sel == 1) ? ld : 1'b0;
    if0.start  = (sel == 0) ? st : 1'b0;  if1.start  = (sel == 1) ? st : 1'b0;
    if0.stop   = (sel == 0) ? sp : 1'b0;  if1.stop   = (sel == 1) ? sp : 1'b0;
    if0.load_value = lv;                  if1.load_value = lv;
  endtask

  // One clock: drive, queue the expectation, compare after the edge.
  task automatic step(input string tag, input int sel, input bit en, input bit ld,
                      input logic [7:0] lv, input bit st, input bit sp,
                      input logic [7:0] ec, input bit eb, input bit ed);
    exp_t e, o;
    drive(sel, en, ld, lv, st, sp);
    e.tag = tag; e.sel = sel; e.cnt = ec; e.busy = eb; e.done = ed;
    exp_q.push_back(e);
    @(posedge clk); #1;
    o = exp_q.pop_front();
    if (o.sel == 0) begin
      chk({o.tag, ".count"}, 32'(if0.count), 32'(o.cnt));
      chk({o.tag, ".busy"},  32'(if0.busy),  32'(o.busy));
      chk({o.tag, ".done"},  32'(if0.done),  32'(o.done));
    end else begin
      chk({o.tag, ".count"}, 32'(if1.count), 32'(o.cnt));
      chk({o.tag, ".busy"},  32'(if1.busy),  32'(o.busy));
      chk({o.tag, ".done"},  32'(if1.done),  32'(o.done));
      if (if1.done) n_done1++;
    end
  endtask

  initial begin
    logic [7:0] ar_seq [9];
    ar_seq = '{8'd2, 8'd1, 8'd3, 8'd2, 8'd1, 8'd3, 8'd2, 8'd1, 8'd3};
    drive(0, 0, 0, 8'h00, 0, 0);

    // Reset held for 5 cycles, then idle with no commands
    repeat (5) @(posedge clk);
    #1;
    chk("rst.count", 32'(if0.count), 0);
    chk("rst.busy",  32'(if0.busy),  0);
    chk("rst.done",  32'(if0.done),  0);
    reset = 1'b1;
    for (int i = 0; i < 3; i++) step("idle", 0, 1, 0, 8'h00, 0, 0, 8'h00, 0, 0);

    // Load 5, start, count down with enable held high
    step("ld5",   0, 0, 1, 8'h05, 0, 0, 8'h05, 0, 0);
    step("st5",   0, 0, 0, 8'h00, 1, 0, 8'h05, 1, 0);
    for (int k = 1; k <= 4; k++) step("run5", 0, 1, 0, 8'h00, 0, 0, 8'(5 - k), 1, 0);
    step("exp5",  0, 1, 0, 8'h00, 0, 0, 8'h00, 0, 1);
    step("post5", 0, 1, 0, 8'h00, 0, 0, 8'h00, 0, 0);

    // Gated counting: enable 0,1,0,1,...
    step("ld4", 0, 0, 1, 8'h04, 0, 0, 8'h04, 0, 0);
    step("st4", 0, 0, 0, 8'h00, 1, 0, 8'h04, 1, 0);
    for (int c = 0; c < 7; c++)
      step("gate", 0, c[0], 0, 8'h00, 0, 0, 8'(4 - (c + 1) / 2), 1, 0);
    step("gate.exp", 0, 1, 0, 8'h00, 0, 0, 8'h00, 0, 1);

    // Stop holds count; stop beats start; load mid-run returns to IDLE
    step("ld6",    0, 0, 1, 8'h06, 0, 0, 8'h06, 0, 0);
    step("st6",    0, 1, 0, 8'h00, 1, 0, 8'h06, 1, 0);
    step("run6a",  0, 1, 0, 8'h00, 0, 0, 8'h05, 1, 0);
    step("stop",   0, 1, 0, 8'h00, 0, 1, 8'h05, 0, 0);
    step("hold",   0, 1, 0, 8'h00, 0, 0, 8'h05, 0, 0);
    step("restart",0, 1, 0, 8'h00, 1, 0, 8'h05, 1, 0);
    step("run6b",  0, 1, 0, 8'h00, 0, 0, 8'h04, 1, 0);
    step("stopst", 0, 1, 0, 8'h00, 1, 1, 8'h04, 0, 0);
    step("st6c",   0, 1, 0, 8'h00, 1, 0, 8'h04, 1, 0);
    step("ldrun",  0, 1, 1, 8'h07, 0, 0, 8'h07, 0, 0);

    // Start with count 0 expires immediately, again from EXPIRED
    step("ld0",   0, 0, 1, 8'h00, 0, 0, 8'h00, 0, 0);
    step("st0",   0, 1, 0, 8'h00, 1, 0, 8'h00, 0, 1);
    step("st0.p", 0, 1, 0, 8'h00, 0, 0, 8'h00, 0, 0);
    step("st0b",  0, 1, 0, 8'h00, 1, 0, 8'h00, 0, 1);

    // Load and start on the same edge: load wins
    step("ldst",  0, 1, 1, 8'h03, 1, 0, 8'h03, 0, 0);
    step("ldst2", 0, 1, 0, 8'h00, 1, 0, 8'h03, 1, 0);
    step("ldst3", 0, 1, 0, 8'h00, 0, 0, 8'h02, 1, 0);

    // Full-range run from 0xFF stops at 0, never wraps
    step("ldff", 0, 0, 1, 8'hFF, 0, 0, 8'hFF, 0, 0);
    step("stff", 0, 1, 1'b0, 8'h00, 1, 0, 8'hFF, 1, 0);
    for (int k = 1; k < 255; k++) step("runff", 0, 1, 0, 8'h00, 0, 0, 8'(255 - k), 1, 0);
    step("expff", 0, 1, 0, 8'h00, 0, 0, 8'h00, 0, 1);
    for (int k = 0; k < 3; k++) step("nowrap", 0, 1, 0, 8'h00, 0, 0, 8'h00, 0, 0);

    // Reset asserted mid-run, between edges
    step("ld10", 0, 0, 1, 8'h10, 0, 0, 8'h10, 0, 0);
    step("st10", 0, 1, 0, 8'h00, 1, 0, 8'h10, 1, 0);
    for (int k = 1; k <= 5; k++) step("run10", 0, 1, 0, 8'h00, 0, 0, 8'(16 - k), 1, 0);
    #2 reset = 1'b0;
    #1;
    chk("arst.count", 32'(if0.count), 0);
    chk("arst.busy",  32'(if0.busy),  0);
    chk("arst.done",  32'(if0.done),  0);
    @(posedge clk); #3 reset = 1'b1;
    @(posedge clk); #1;
    chk("arst.hold", 32'(if0.count), 0);
    step("arst.st",  0, 1, 0, 8'h00, 1, 0, 8'h00, 0, 1);
    step("arst.p",   0, 1, 0, 8'h00, 0, 0, 8'h00, 0, 0);

    // Auto-reload instance: L=3 gives 2,1,3 repeating
    step("ar.ld", 1, 0, 1, 8'h03, 0, 0, 8'h03, 0, 0);
    step("ar.st", 1, 0, 0, 8'h00, 1, 0, 8'h03, 1, 0);
    n_done1 = 0;
    for (int k = 0; k < 9; k++)
      step("ar.run", 1, 1, 0, 8'h00, 0, 0, ar_seq[k], 1, (k % 3 == 2));
    chk("ar.npulse", 32'(n_done1), 3);
    step("ar.stop", 1, 1, 0, 8'h00, 0, 1, 8'h03, 0, 0);

    drive(0, 0, 0, 8'h00, 0, 0);
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
